fetch_stage: RTL and testbench

//  Instruction fetch stage of the RV32I core. Owns the PC, issues in-order word

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues in-order word reads to instruction
// memory and buffers the returned words with their PC tags for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [31:0]     START_PC = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W:0]  DEPTH    = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] live_q, live_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0] inst_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];
    logic [31:0] tag_mem  [FIFO_DEPTH];

    logic             issue, resp, resp_drop, resp_live, push, pop;
    logic [CNT_W-1:0] live_ret, drop_ret;

    // A slot freed by a pop only counts from the next cycle: count_q is used, not count_d.
    assign imem_req  = !rst && !redirect
                     && (({1'b0, live_q} + {1'b0, count_q}) < DEPTH)
                     && (({1'b0, live_q} + {1'b0, drop_q})  < DEPTH);
    assign imem_addr = rst ? START_PC : pc_q;

    assign id_valid = !rst && (count_q != '0);
    assign id_inst  = id_valid ? inst_mem[rd_q] : NOP;
    assign id_pc    = id_valid ? pc_mem[rd_q]   : 32'h0;

    assign issue     = imem_req && imem_gnt;
    assign resp      = imem_rvalid && ((live_q != '0) || (drop_q != '0));
    assign resp_drop = resp && (drop_q != '0);
    assign resp_live = resp && (drop_q == '0);
    assign pop       = id_valid && id_ready;
    assign push      = resp_live && !redirect;

    // Counters after accounting for this cycle's response, before redirect/issue.
    assign drop_ret = drop_q - CNT_W'(resp_drop);
    assign live_ret = live_q - CNT_W'(resp_live);

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        live_d   = live_ret;
        drop_d   = drop_ret;
        wr_d     = wr_q;
        rd_d     = rd_q;
        tag_wr_d = tag_wr_q;
        tag_rd_d = tag_rd_q;
        if (redirect) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            live_d   = '0;
            drop_d   = drop_ret + live_ret;
            wr_d     = '0;
            rd_d     = '0;
            tag_wr_d = '0;
            tag_rd_d = '0;
        end else begin
            live_d  = live_ret + CNT_W'(issue);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                pc_d     = pc_q + 32'd4;
                tag_wr_d = tag_wr_q + PTR_W'(1);
            end
            if (resp_live) tag_rd_d = tag_rd_q + PTR_W'(1);
            if (push)      wr_d     = wr_q + PTR_W'(1);
            if (pop)       rd_d     = rd_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= START_PC;
            count_q  <= '0;
            live_q   <= '0;
            drop_q   <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            live_q   <= live_d;
            drop_q   <= drop_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // Storage needs no reset: entries are only read while count/live cover them.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_q] <= imem_rdata;
            pc_mem[wr_q]   <= tag_mem[tag_rd_q];
        end
        if (issue) tag_mem[tag_wr_q] <= pc_q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rvalid && (live_q == '0) && (drop_q == '0)))
                else $error("fetch_stage: imem_rvalid with no read outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model on the bus and a reference model
// that tracks in-flight reads as stale/fresh entries and the decode queue.
module tb_fetch_stage;
    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, imem_req, imem_gnt, imem_rvalid, redirect, id_valid, id_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc;

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // memory environment
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          lat_min = 1, lat_max = 1, resp_pct = 100;
    logic [31:0] data_key = 32'h0;

    // reference model
    logic [31:0] m_pc = RPC;
    logic [31:0] f_inst[$];
    logic [31:0] f_pc[$];
    logic [31:0] if_pc[$];
    bit          if_stale[$];

    logic [97:0] got, want;

    function automatic int live_cnt();
        int n = 0;
        foreach (if_stale[i]) if (!if_stale[i]) n++;
        return n;
    endfunction

    // {imem_req, imem_addr, id_valid, id_inst, id_pc}
    function automatic logic [97:0] exp_out();
        logic r, v;
        logic [31:0] a, ins, p;
        r   = !rst && !redirect && ((live_cnt() + f_inst.size()) < D) && (if_pc.size() < D);
        a   = rst ? RPC : m_pc;
        v   = !rst && (f_inst.size() != 0);
        ins = v ? f_inst[0] : NOP;
        p   = v ? f_pc[0] : 32'h0;
        return {r, a, v, ins, p};
    endfunction

    function automatic logic [97:0] dut_out();
        return {imem_req, imem_addr, id_valid, id_inst, id_pc};
    endfunction

    task automatic settle();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc
            && $urandom_range(99, 0) < resp_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_addr_q[0] ^ data_key;
        end
        #1;
    endtask

    task automatic advance();
        logic [97:0] e;
        bit m_issue, m_pop, s;
        logic [31:0] p;
        e       = exp_out();
        m_issue = e[97] && imem_gnt;
        m_pop   = e[64] && id_ready;
        if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (imem_rvalid) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (imem_req && imem_gnt) begin
                mem_addr_q.push_back(imem_addr);
                mem_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            end
        end
        if (rst) begin
            m_pc = RPC;
            f_inst.delete(); f_pc.delete(); if_pc.delete(); if_stale.delete();
        end else begin
            if (m_pop) begin
                void'(f_inst.pop_front());
                void'(f_pc.pop_front());
            end
            if (imem_rvalid && if_pc.size() > 0) begin
                p = if_pc.pop_front();
                s = if_stale.pop_front();
                if (!s && !redirect) begin
                    f_inst.push_back(imem_rdata);
                    f_pc.push_back(p);
                end
            end
            if (redirect) begin
                f_inst.delete(); f_pc.delete();
                foreach (if_stale[i]) if_stale[i] = 1'b1;
                m_pc = redirect_pc & ~32'h3;
            end else if (m_issue) begin
                if_pc.push_back(m_pc);
                if_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; redirect = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, got, want); end
            n_total++;
            if (got !== {1'b0, RPC, 1'b0, NOP, 32'h0}) begin
                n_bad++; $display("FAIL reset_values cyc=%0d got=%h want=%h", cyc, got, {1'b0, RPC, 1'b0, NOP, 32'h0});
            end
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int first = -1;
        logic [31:0] seq = 32'h0;
        data_key = 32'h0; lat_min = 1; lat_max = 1; resp_pct = 100;
        imem_gnt = 1'b1; id_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL stream cyc=%0d got=%h want=%h", cyc, got, want); end
            if (id_valid) begin
                n_total++;
                if (id_inst !== id_pc || id_pc !== seq) begin
                    n_bad++; $display("FAIL stream_order cyc=%0d got=%h/%h want=%h/%h", cyc, id_inst, id_pc, seq, seq);
                end
                seq = seq + 32'd4;
                if (first < 0) first = c;
            end
            advance();
        end
        n_total++;
        if (first != 2) begin n_bad++; $display("FAIL stream_latency got=%0d want=2", first); end
    endtask

    task automatic test_stall();
        logic [31:0] held = 32'h0, nxt;
        id_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL stall cyc=%0d got=%h want=%h", cyc, got, want); end
            if (c >= 5) begin
                n_total++;
                if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== held) begin
                    n_bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%h want=0/1/%h", cyc, imem_req, id_valid, id_pc, held);
                end
            end
            if (c == 4) held = id_pc;
            advance();
        end
        id_ready = 1'b1;
        nxt = held;
        for (int c = 0; c < 12; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL stall_release cyc=%0d got=%h want=%h", cyc, got, want); end
            if (id_valid) begin
                n_total++;
                if (id_pc !== nxt || id_inst !== nxt) begin
                    n_bad++; $display("FAIL stall_order cyc=%0d got=%h want=%h", cyc, id_pc, nxt);
                end
                nxt = nxt + 32'd4;
            end
            advance();
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] nxt;
        lat_min = 3; lat_max = 3; data_key = $urandom; imem_gnt = 1'b1; id_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (live_cnt() == 2) break;
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL redir_fill cyc=%0d got=%h want=%h", cyc, got, want); end
            advance();
        end
        if (live_cnt() != 2) begin n_total++; n_bad++; $display("FAIL redir_setup got=%0d want=2", live_cnt()); end
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        settle();
        got = dut_out(); want = exp_out(); n_total++;
        if (got !== want) begin n_bad++; $display("FAIL redir_cycle cyc=%0d got=%h want=%h", cyc, got, want); end
        n_total++;
        if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req got=%b want=0", imem_req); end
        advance();
        redirect = 1'b0;
        nxt = 32'h0000_0100;
        for (int c = 0; c < 20; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL redir_after cyc=%0d got=%h want=%h", cyc, got, want); end
            if (id_valid) begin
                n_total++;
                if (id_pc !== nxt || id_inst !== (nxt ^ data_key)) begin
                    n_bad++; $display("FAIL redir_stale cyc=%0d got=%h/%h want=%h/%h", cyc, id_pc, id_inst, nxt, nxt ^ data_key);
                end
                nxt = nxt + 32'd4;
            end
            advance();
        end
    endtask

    task automatic test_redirect_collide();
        bit hit = 1'b0;
        logic [31:0] nxt = 32'h0;
        lat_min = 1; lat_max = 1; resp_pct = 100; imem_gnt = 1'b1; id_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            settle();
            if (id_valid && imem_rvalid) begin
                hit = 1'b1;
                redirect = 1'b1;
                redirect_pc = 32'h0000_4000 + (32'($urandom_range(255, 0)) << 2) + 32'($urandom_range(3, 0));
                nxt = redirect_pc & ~32'h3;
                #1;
            end
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL collide cyc=%0d got=%h want=%h", cyc, got, want); end
            advance();
            if (hit) break;
        end
        redirect = 1'b0;
        if (!hit) begin n_total++; n_bad++; $display("FAIL collide_setup got=0 want=1"); end
        for (int c = 0; c < 10; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL collide_after cyc=%0d got=%h want=%h", cyc, got, want); end
            if (id_valid) begin
                n_total++;
                if (id_pc !== nxt) begin n_bad++; $display("FAIL collide_order cyc=%0d got=%h want=%h", cyc, id_pc, nxt); end
                nxt = nxt + 32'd4;
            end
            advance();
        end
    endtask

    task automatic test_gnt_hold();
        id_ready = 1'b1; imem_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        settle();
        got = dut_out(); want = exp_out(); n_total++;
        if (got !== want) begin n_bad++; $display("FAIL gnt_redir cyc=%0d got=%h want=%h", cyc, got, want); end
        advance();
        redirect = 1'b0;
        for (int c = 0; c < 10; c++) begin
            want = exp_out();
            if (want[97]) break;
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL gnt_drain cyc=%0d got=%h want=%h", cyc, got, want); end
            advance();
        end
        want = exp_out();
        if (!want[97]) begin n_total++; n_bad++; $display("FAIL gnt_setup got=0 want=1"); end
        for (int c = 0; c < 5; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL gnt_model cyc=%0d got=%h want=%h", cyc, got, want); end
            n_total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
                n_bad++; $display("FAIL gnt_hold cyc=%0d got=%b/%h want=1/fffffffc", cyc, imem_req, imem_addr);
            end
            advance();
        end
        imem_gnt = 1'b1;
        settle();
        got = dut_out(); want = exp_out(); n_total++;
        if (got !== want) begin n_bad++; $display("FAIL gnt_issue cyc=%0d got=%h want=%h", cyc, got, want); end
        advance();
        settle();
        n_total++;
        if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL pc_wrap got=%h want=00000000", imem_addr); end
        advance();
        for (int c = 0; c < 8; c++) begin
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL wrap_after cyc=%0d got=%h want=%h", cyc, got, want); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            lat_min = (pass == 0) ? 1 : 4; lat_max = lat_min;
            imem_gnt = 1'b1; id_ready = (pass == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 20; c++) begin
                if (pass == 0 && c >= 8) break;
                if (pass == 1 && live_cnt() == 2) break;
                settle();
                got = dut_out(); want = exp_out(); n_total++;
                if (got !== want) begin n_bad++; $display("FAIL rstmid_fill cyc=%0d got=%h want=%h", cyc, got, want); end
                advance();
            end
            rst = 1'b1;
            for (int c = 0; c < 2; c++) begin
                settle();
                n_total++;
                if (imem_req !== 1'b0 || id_valid !== 1'b0 || imem_addr !== RPC) begin
                    n_bad++; $display("FAIL rstmid_hold cyc=%0d got=%b/%b/%h want=0/0/%h", cyc, imem_req, id_valid, imem_addr, RPC);
                end
                advance();
            end
            rst = 1'b0; id_ready = 1'b1;
            for (int c = 0; c < 10; c++) begin
                settle();
                got = dut_out(); want = exp_out(); n_total++;
                if (got !== want) begin n_bad++; $display("FAIL rstmid_after cyc=%0d got=%h want=%h", cyc, got, want); end
                advance();
            end
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 3; resp_pct = 75; data_key = $urandom;
        for (int c = 0; c < 400; c++) begin
            imem_gnt    = ($urandom_range(99, 0) < 70);
            id_ready    = ($urandom_range(99, 0) < 60);
            redirect    = ($urandom_range(99, 0) < 5);
            redirect_pc = $urandom;
            settle();
            got = dut_out(); want = exp_out(); n_total++;
            if (got !== want) begin n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, want); end
            advance();
        end
        redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; id_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_gnt_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
